// File: rtl/rst_seq_gen.sv
// rst_seq_gen: staggered reset sequencer with per-channel clock-enable dividers
// and a restart watchdog.
//
// Reset domains assert asynchronously with rst_n_i and release synchronously,
// one channel at a time. Every output is a flop. The release mask is decoded
// from the FSM state and registered once more onto rst_o, so each output
// change lands one edge after the state change that causes it.
//
// state   | meaning
// --------+------------------------------------------------------------
// HOLD    | all channels in reset; counts hold cycles once synchronised
// RELEASE | channels 0..idx released; waits STAGGER cycles per channel
// RUN     | all channels released; done_o high; watchdog armed

module rst_seq_gen #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int RST_CYCLES  = 32,
    parameter int STAGGER     = 8,
    parameter int DIV_W       = 8,
    parameter int TIMEOUT     = 1000000
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    sw_rst_i,
    input  logic                    wdg_kick_i,
    input  logic [N_CH*DIV_W-1:0]   div_i,
    output logic [N_CH-1:0]         rst_o,
    output logic [N_CH-1:0]         rst_n_o,
    output logic [N_CH-1:0]         ce_o,
    output logic                    done_o,
    output logic                    wdg_to_o
);

    localparam int CNT_MAX = (RST_CYCLES > STAGGER) ? RST_CYCLES : STAGGER;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit WD_EN   = (TIMEOUT > 0);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);
    // Index of the channel whose stagger period ends in the jump to RUN.
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'((N_CH > 1) ? (N_CH - 2) : 0);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_ok;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   expire;

    logic [N_CH-1:0]        released;
    logic [N_CH-1:0]        rst_q;
    logic [N_CH-1:0]        rst_n_q;
    logic                   done_q;
    logic                   wdg_q;
    logic [N_CH-1:0]        ce_bits;

    // Reset-release synchroniser: clears asynchronously and fills with ones.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_ok = sync_q[SYNC_STAGES-1];

    // Sequencer state, shared hold/stagger counter, channel index and watchdog.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
        end
    end

    // Next-state logic; a software restart outranks watchdog expiry, and a
    // kick in the final watchdog cycle still counts as a kick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wd_d    = '0;
        expire  = 1'b0;

        if (!sync_ok || sw_rst_i) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = (N_CH == 1) ? ST_RUN : ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                ST_RELEASE: begin
                    if (cnt_q == STAG_LAST) begin
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_RUN;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                ST_RUN: begin
                    if (WD_EN) begin
                        if (wdg_kick_i) begin
                            wd_d = '0;
                        end else if (wd_q == WD_LAST) begin
                            expire  = 1'b1;
                            state_d = ST_HOLD;
                            cnt_d   = '0;
                            idx_d   = '0;
                        end else begin
                            wd_d = wd_q + 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Decode which channels the current state has let out of reset.
    always_comb begin
        released = '0;
        case (state_q)
            ST_RELEASE: begin
                for (int i = 0; i < N_CH; i++) begin
                    released[i] = (i <= int'(idx_q));
                end
            end
            ST_RUN:  released = '1;
            default: released = '0;
        endcase
    end

    // Registered reset, done and watchdog outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rst_q   <= '1;
            rst_n_q <= '0;
            done_q  <= 1'b0;
            wdg_q   <= 1'b0;
        end else begin
            rst_q   <= ~released;
            rst_n_q <= released;
            done_q  <= (state_q == ST_RUN);
            wdg_q   <= expire;
        end
    end

    // Per-channel clock-enable dividers. They key off the same release mask
    // as rst_o, so the first enable can coincide with the release edge.
    for (genvar g = 0; g < N_CH; g++) begin : g_div
        logic [DIV_W-1:0] ratio;
        logic [DIV_W-1:0] c_q;
        logic             ce_q;

        assign ratio = div_i[g*DIV_W +: DIV_W];

        // Divider counter; a ratio dropped below the count wraps immediately.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                c_q  <= '0;
                ce_q <= 1'b0;
            end else if (!released[g]) begin
                c_q  <= '0;
                ce_q <= 1'b0;
            end else if (ratio <= DIV_W'(1)) begin
                c_q  <= '0;
                ce_q <= 1'b1;
            end else if (c_q >= ratio - 1'b1) begin
                c_q  <= '0;
                ce_q <= 1'b1;
            end else begin
                c_q  <= c_q + 1'b1;
                ce_q <= 1'b0;
            end
        end

        assign ce_bits[g] = ce_q;
    end

    assign rst_o    = rst_q;
    assign rst_n_o  = rst_n_q;
    assign ce_o     = ce_bits;
    assign done_o   = done_q;
    assign wdg_to_o = wdg_q;

endmodule

// File: doc/rst_seq_gen.md
# rst_seq_gen

Synthesisable, parametrised reset sequencer and clock-enable generator. It is the in-fabric successor of the testbench clock/reset generator. It takes one board clock and an asynchronous active-low reset, and produces N_CH reset domains. Each domain is asserted asynchronously and released synchronously in a staggered order, with a programmable clock-enable divider per domain. A watchdog restarts the sequence when software stops kicking it. It sits at the top level, between the PLL/board reset and the DSP/FIFO/interface blocks.

## Interface
- N_CH, 4: number of reset/clock-enable channels (1..16)
- SYNC_STAGES, 2: reset-release synchroniser depth (>=2)
- RST_CYCLES, 32: hold cycles after synchronised release before channel 0 releases (>=1)
- STAGGER, 8: cycles between consecutive channel releases (>=1)
- DIV_W, 8: width of each per-channel divide ratio
- TIMEOUT, 1000000: watchdog period in cycles; 0 disables the watchdog

- clk_i  in  1  system clock
- rst_n_i  in  1  reset, asynchronous, active-low; one clock
- sw_rst_i  in  1  synchronous software restart request, level-sampled
- wdg_kick_i  in  1  watchdog kick, sampled each cycle
- div_i  in  N_CH*DIV_W  divide ratio d per channel; channel k uses bits [k*DIV_W +: DIV_W]
- rst_o  out  N_CH  active-high channel resets
- rst_n_o  out  N_CH  active-low channel resets, always the complement of rst_o
- ce_o  out  N_CH  per-channel clock enables
- done_o  out  1  high while all channels are released
- wdg_to_o  out  1  one-cycle pulse on watchdog expiry

## Operation
- Async reset (rst_n_i low):
  - immediately forces rst_o all 1, rst_n_o all 0, ce_o 0, done_o 0, wdg_to_o 0.
  - Synchroniser cleared; state HOLD; counters 0.
- Release path: rst_n_i passes a SYNC_STAGES flop chain. HOLD does not count until the chain output is 1.
- FSM states:
  - HOLD: counts RST_CYCLES cycles, then goes to RELEASE with index k=0.
  - RELEASE: deasserts channel k, then waits STAGGER cycles and increments k. When k=N_CH-1 deasserts, the FSM goes to RUN.
  - RUN: all channels released; done_o=1; the watchdog is active.
- Restart: sw_rst_i=1 in any state after synchronisation means that on the next cycle all rst_o reassert, ce_o=0, done_o=0, HOLD restarts from 0.
  - sw_rst_i held high keeps the FSM in HOLD at count 0.
- Watchdog, in RUN only:
  - The counter clears to 0 on wdg_kick_i and otherwise increments.
  - If the counter equals TIMEOUT-1 with no kick, wdg_to_o pulses for one cycle and a restart follows, as for sw_rst_i.
  - The counter is held at 0 outside RUN.
- Priority when events coincide: rst_n_i > sw_rst_i > watchdog expiry. If sw_rst_i and expiry coincide, the restart happens once and wdg_to_o stays 0. A kick in the expiry cycle prevents expiry.
- Clock-enable divider, per channel, DIV_W-bit counter c:
  - c is held at 0 while the channel is in reset.
  - d in {0,1}: ce_o[k]=1 on every released cycle.
  - d>=2: ce_o[k]=1 when c>=d-1, and c wraps to 0; otherwise c increments.
  - div_i is read live. A ratio decrease below the current c produces one ce pulse and a wrap, never a counter overrun.

## Timing
- All outputs are registered. rst_o deassertion and ce_o are synchronous to the rising edge of clk_i. Assertion is asynchronous only via rst_n_i.
- Cycle 0 is the first rising edge with rst_n_i high. Channel k releases at cycle SYNC_STAGES+RST_CYCLES+k*STAGGER.
  - Defaults give channel 0 at 34, 1 at 42, 2 at 50, 3 at 58.
  - done_o rises in the same cycle as the last release.
- Channel k with d>=2: the first released cycle is r. ce_o[k] is high at r+d-1, r+2d-1, and so on.
- Restart latency: sw_rst_i sampled high at edge n gives rst_o all 1 after edge n+1. Release then repeats with offset RST_CYCLES+k*STAGGER from the first cycle sw_rst_i is low, with no synchroniser delay.
- Watchdog: the last kick at cycle n with no further kicks gives wdg_to_o high at cycle n+TIMEOUT and rst_o reasserted at n+TIMEOUT+1.

## Test plan
- Power-up, defaults: deassert rst_n_i at t0. Expect rst_o = 1111→1110 at cycle 34, 1100 at 42, 1000 at 50, 0000 at 58, and done_o high at 58.
- Divider: d0=0, d1=1, d2=3, d3=200. Expect ce0 and ce1 continuous. Expect ce2 at r+2, r+5, …. Expect ce3 at r+199 and then every 200 cycles. Change d3 from 200 to 5 at c=50: expect one pulse next cycle, then a period of 5.
- Software restart: pulse sw_rst_i for 1 cycle in RUN. Expect all resets reasserted next cycle, done_o low, and channel 0 released 32 cycles after the pulse ends. Hold it 10 cycles mid-RELEASE: the sequence restarts only after the drop.
- Watchdog (TIMEOUT=100): kick every 99 cycles and expect no expiry. Stop kicking: expect a wdg_to_o pulse 100 cycles after the last kick, a full re-sequence, and done_o again 32+3*8 cycles later.
- Async mid-operation: drop rst_n_i between clock edges during RELEASE. Expect rst_o all 1 and ce_o 0 without waiting for an edge. Release it: the timing repeats from the power-up case, including SYNC_STAGES.
- Coincidence: sw_rst_i high in the watchdog expiry cycle. Expect one restart and wdg_to_o=0. Kick in the expiry cycle: no restart.
